prog_clk_divider: RTL
=====================

// Module: prog_clk_divider
// PURPOSE
//  Multi-channel programmable clock-enable/clock divider. Each channel divides clk_in by a
//  runtime divisor and produces a registered divided clock and a one-cycle period tick.
//  Divisor updates are glitch-free: a new divisor takes effect only at a period boundary.
//  A common sync pulse phase-aligns all channels. Feeds peripheral timing (UART/PWM/LED).
// PARAMETERS
//  NCH      4   number of independent channels (>=1)
//  W        8   divisor / counter width in bits (>=2)
//  DEF_DIV  2   active divisor loaded at reset (2..2^W-1)
// PORTS
//  clk_in    in   1        single clock; all logic on posedge
//  rst_n     in   1        asynchronous active-low reset
//  div_in    in   NCH*W    divisor per channel; ch i = div_in[i*W +: W]
//  div_load  in   NCH      1-cycle strobe: capture div_in slice of ch i into shadow reg
//  en        in   NCH      channel enable (level)
//  sync      in   1        1-cycle strobe: restart all enabled channels at count 0
//  clk_out   out  NCH      divided clock, registered
//  tick      out  NCH      1-cycle pulse, last cycle of each output period
//  pending   out  NCH      shadow divisor captured but not yet applied
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, active=DEF_DIV, shadow=DEF_DIV, clk_out=0, tick=0, pending=0.
//  Divisor encoding: D=0 -> channel off (clk_out=0, tick=0, cnt held 0); D=1 -> treated as D=2.
//  Counting (en=1, D>=2): cnt runs 0..D-1 then wraps to 0. Registered outputs, 1-cycle latency:
//   clk_out <= (cnt < D>>1); tick <= (cnt == D-1). High time floor(D/2), low time ceil(D/2).
//   D=2: 1010..., D=5: 2 high / 3 low, period D cycles.
//  Load: div_load[i]=1 -> shadow<=slice, pending<=1. Repeated load while pending overwrites shadow.
//  Apply: at the edge where cnt==D-1 and pending=1: active<=shadow, cnt<=0, pending<=0.
//   The period in progress always completes with the old divisor; no runt pulses.
//  Load and apply same cycle: the newly captured value is applied (shadow bypass).
//  en=0: cnt<=0, clk_out<=0, tick<=0; if pending, active<=shadow and pending<=0 at once.
//  en rising: counting starts at cnt=0; first clk_out high appears 1 cycle after en=1 is seen.
//  sync=1: every enabled channel cnt<=0 and applies a pending divisor immediately (sync is a
//   boundary); clk_out/tick follow from cnt=0 next cycle. sync wins over normal wrap.
//  Active divisor lowered below current cnt cannot occur (apply only at wrap/sync/disable).
//  rst_n asserted mid-period: immediate return to reset values; no completion of period.
//  All width arithmetic in W bits; D-1 computed only for D>=2, no underflow path.
// STRUCTURE
//  Shared package/include clk_div_pkg: DIV_OFF=0, DIV_MIN=2, default W/DEF_DIV constants.
//  Sub-module clk_div_chan (one channel: shadow, active, cnt, pending, outputs), generated
//  NCH times; top only slices div_in and fans out sync. No cross-channel state.
// TESTING
//  1. Reset, en=1 ch0, D=DEF_DIV=2 -> clk_out[0] toggles 0,1,0,1; tick[0] every 2nd cycle.
//  2. Load D=4 mid-period of D=2 -> pending=1 until wrap, then pattern 1100 repeating, tick/4.
//  3. D=5 -> clk_out high 2, low 3; tick coincides with last low cycle before rise.
//  4. Ch0 D=3, ch1 D=6, pulse sync -> both cnt=0 same edge; rising edges aligned every 6 cycles.
//  5. D=0 -> clk_out=0, tick=0 continuously; D=1 loaded -> behaves as D=2.
//  6. rst_n low mid-period with pending=1 -> outputs 0, pending 0, active=DEF_DIV immediately.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// Divisor encoding: 0 switches a channel off, 1 runs as 2.
package clk_div_pkg;

    localparam int DEF_NCH  = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_DIV  = 2;
    localparam int DIV_OFF  = 0;
    localparam int DIV_MIN  = 2;

    typedef enum logic [1:0] {
        MODE_DISABLED = 2'd0,
        MODE_OFF      = 2'd1,
        MODE_RUN      = 2'd2
    } chan_mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active divisor pair, period counter and registered outputs.
// Divisor changes are applied only at a period boundary (wrap, sync, disable or channel off).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [W-1:0] i_div,
    input  logic         i_load,
    input  logic         i_en,
    input  logic         i_sync,
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_pending
);

    logic [W-1:0] r_shadow;
    logic [W-1:0] r_active;
    logic [W-1:0] r_cnt;
    logic         r_pending;
    logic         r_clk;
    logic         r_tick;

    logic [W-1:0] w_new_shadow;
    logic         w_has_pend;
    logic [W-1:0] w_deff;
    logic [W-1:0] w_last_val;
    logic [W-1:0] w_half;
    logic         w_at_last;
    logic         w_boundary;
    chan_mode_e   w_mode;

    // Effective divisor: a programmed 1 runs as the minimum divisor of 2.
    function automatic logic [W-1:0] eff_div(input logic [W-1:0] d);
        eff_div = (d == W'(1)) ? W'(DIV_MIN) : d;
    endfunction

    // Decode channel mode, boundary condition and the shadow bypass value.
    always_comb begin
        w_new_shadow = i_load ? i_div : r_shadow;
        w_has_pend   = i_load | r_pending;
        w_deff       = eff_div(r_active);
        w_half       = w_deff >> 1;
        w_mode       = MODE_RUN;
        w_last_val   = {W{1'b0}};
        w_at_last    = 1'b0;
        case ({i_en, (r_active == W'(DIV_OFF))})
            2'b00, 2'b01: w_mode = MODE_DISABLED;
            2'b11:        w_mode = MODE_OFF;
            2'b10:        w_mode = MODE_RUN;
            default:      w_mode = MODE_DISABLED;
        endcase
        // D-1 is only formed for a running channel, where D is at least 2.
        w_last_val = (w_mode == MODE_RUN) ? (w_deff - W'(1)) : {W{1'b0}};
        w_at_last  = (w_mode == MODE_RUN) ? (r_cnt == w_last_val) : 1'b0;
        w_boundary = (w_mode != MODE_RUN) | i_sync | w_at_last;
    end

    // Divisor bookkeeping, period counter and registered clock/tick outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= W'(DEF_DIV);
            r_active  <= W'(DEF_DIV);
            r_cnt     <= {W{1'b0}};
            r_pending <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_shadow <= w_new_shadow;
            if (w_boundary && w_has_pend) begin
                r_active  <= w_new_shadow;
                r_pending <= 1'b0;
            end else begin
                r_pending <= w_has_pend;
            end
            case (w_mode)
                MODE_RUN: begin
                    r_clk  <= (r_cnt < w_half);
                    r_tick <= w_at_last;
                    r_cnt  <= (i_sync || w_at_last) ? {W{1'b0}} : (r_cnt + W'(1));
                end
                MODE_OFF, MODE_DISABLED: begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_cnt  <= {W{1'b0}};
                end
                default: begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_cnt  <= {W{1'b0}};
                end
            endcase
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: slices the divisor bus per channel and
// fans out the common sync strobe. Channels share no state.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int W       = DEF_W,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] div_in,
    input  logic [NCH-1:0]   div_load,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            clk_div_chan #(
                .W       (W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk_in    (clk_in),
                .rst_n     (rst_n),
                .i_div     (div_in[g*W +: W]),
                .i_load    (div_load[g]),
                .i_en      (en[g]),
                .i_sync    (sync),
                .o_clk     (clk_out[g]),
                .o_tick    (tick[g]),
                .o_pending (pending[g])
            );
        end
    endgenerate

endmodule
